apu_issue_queue: RTL and testbench

Parametrised APU front-end buffer between the core's APU request/response port and the vector decoder/execution back-end. Accepted requests (operands, op, flags) are queued in a DEPTH-entry in-order FIFO and presented to the back-end with a valid/ready handshake. The total number of accepted-but-unanswered instructions is capped, and results come back to the core as a registered `apu_rvalid`/`apu_result` pulse. It replaces the direct combinational `apu_gnt` path so the core can run ahead of a stalled vector unit.

---
 rtl/apu_issue_queue.sv | 113 +++++++++++
 tb/tb_apu_issue_queue.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/apu_issue_queue.sv
// In-order APU request buffer: queues accepted core requests for the vector back-end,
// caps outstanding instructions, and returns back-end results as a registered pulse.
module apu_issue_queue #(
  parameter int DEPTH        = 4,
  parameter int NUM_OPS      = 3,
  parameter int OP_W         = 6,
  parameter int FLAGS_W      = 15,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          apu_req,
  output logic                          apu_gnt,
  input  logic [NUM_OPS*32-1:0]         apu_operands_i,
  input  logic [OP_W-1:0]               apu_op,
  input  logic [FLAGS_W-1:0]            apu_flags_i,
  output logic                          apu_rvalid,
  output logic [31:0]                   apu_result,
  output logic [4:0]                    apu_flags_o,
  input  logic                          flush,
  output logic                          issue_valid,
  input  logic                          issue_ready,
  output logic [NUM_OPS*32-1:0]         issue_operands,
  output logic [OP_W-1:0]               issue_op,
  output logic [FLAGS_W-1:0]            issue_flags,
  input  logic                          result_valid,
  input  logic [31:0]                   result_i,
  output logic [$clog2(DEPTH):0]        count_o,
  output logic [$clog2(MAX_INFLIGHT):0] inflight_o,
  output logic                          err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = $clog2(MAX_INFLIGHT) + 1;

  logic [NUM_OPS*32-1:0] ops_mem   [DEPTH];
  logic [OP_W-1:0]       op_mem    [DEPTH];
  logic [FLAGS_W-1:0]    flags_mem [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [IW-1:0] inflight;
  logic          push, pop, res_ok, flush_dec;

  // No bypass: a full queue refuses even when the head is leaving this cycle.
  assign apu_gnt     = apu_req & ~flush & (count < CW'(DEPTH)) & (inflight < IW'(MAX_INFLIGHT));
  assign issue_valid = (count != '0) & ~flush;
  assign push        = apu_req & apu_gnt;
  assign pop         = issue_valid & issue_ready;
  assign res_ok      = result_valid & (inflight != '0);
  assign flush_dec   = result_valid & (inflight > IW'(count));

  assign issue_operands = ops_mem[rd_ptr];
  assign issue_op       = op_mem[rd_ptr];
  assign issue_flags    = flags_mem[rd_ptr];
  assign apu_flags_o    = '0;
  assign count_o        = count;
  assign inflight_o     = inflight;

  // NOTE: storage has no reset; valid data is tracked by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      ops_mem[wr_ptr]   <= apu_operands_i;
      op_mem[wr_ptr]    <= apu_op;
      flags_mem[wr_ptr] <= apu_flags_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Flushed entries were never issued, so they leave the outstanding count immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inflight <= '0;
    end else if (flush) begin
      inflight <= inflight - IW'(count) - IW'(flush_dec);
    end else if (push && !res_ok) begin
      inflight <= inflight + 1'b1;
    end else if (res_ok && !push) begin
      inflight <= inflight - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_o      <= 1'b0;
      apu_rvalid <= 1'b0;
      apu_result <= '0;
    end else begin
      if (result_valid && inflight == '0) err_o <= 1'b1;
      apu_rvalid <= res_ok;
      if (res_ok) apu_result <= result_i;
    end
  end

endmodule

// File: tb/tb_apu_issue_queue.sv
// Directed and randomized bench for apu_issue_queue against a queue-based reference model.
module tb_apu_issue_queue;

  localparam int DEPTH = 4, NUM_OPS = 3, OP_W = 6, FLAGS_W = 15, MAX_INFLIGHT = 8;

  typedef struct packed {
    logic [NUM_OPS*32-1:0] ops;
    logic [OP_W-1:0]       op;
    logic [FLAGS_W-1:0]    flags;
  } entry_t;

  logic                          clk = 1'b0;
  logic                          reset;
  logic                          apu_req;
  logic                          apu_gnt;
  logic [NUM_OPS*32-1:0]         apu_operands_i;
  logic [OP_W-1:0]               apu_op;
  logic [FLAGS_W-1:0]            apu_flags_i;
  logic                          apu_rvalid;
  logic [31:0]                   apu_result;
  logic [4:0]                    apu_flags_o;
  logic                          flush;
  logic                          issue_valid;
  logic                          issue_ready;
  logic [NUM_OPS*32-1:0]         issue_operands;
  logic [OP_W-1:0]               issue_op;
  logic [FLAGS_W-1:0]            issue_flags;
  logic                          result_valid;
  logic [31:0]                   result_i;
  logic [$clog2(DEPTH):0]        count_o;
  logic [$clog2(MAX_INFLIGHT):0] inflight_o;
  logic                          err_o;

  apu_issue_queue #(
    .DEPTH(DEPTH), .NUM_OPS(NUM_OPS), .OP_W(OP_W), .FLAGS_W(FLAGS_W), .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (
    .clk(clk), .reset(reset), .apu_req(apu_req), .apu_gnt(apu_gnt),
    .apu_operands_i(apu_operands_i), .apu_op(apu_op), .apu_flags_i(apu_flags_i),
    .apu_rvalid(apu_rvalid), .apu_result(apu_result), .apu_flags_o(apu_flags_o),
    .flush(flush), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_operands(issue_operands), .issue_op(issue_op), .issue_flags(issue_flags),
    .result_valid(result_valid), .result_i(result_i), .count_o(count_o),
    .inflight_o(inflight_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: unissued entries in order, plus a count of issued-but-unanswered ones.
  entry_t      fq[$];
  int          issued = 0;
  bit          m_err = 0, m_rvalid = 0;
  logic [31:0] m_result = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("count_o", 128'(count_o), 128'(fq.size()));
    check("inflight_o", 128'(inflight_o), 128'(fq.size() + issued));
    check("apu_rvalid", 128'(apu_rvalid), 128'(m_rvalid));
    check("apu_result", 128'(apu_result), 128'(m_result));
    check("err_o", 128'(err_o), 128'(m_err));
  endtask

  // One clock cycle: drive inputs, check combinational outputs, clock, then check state.
  task automatic cycle(input bit req, input logic [OP_W-1:0] op, input bit fl, input bit rdy,
                       input bit rv, input logic [31:0] rdata);
    entry_t e;
    int     outstanding;
    bit     exp_gnt, exp_iv, res_ok;
    e.ops  = {$urandom(), $urandom(), $urandom()};
    e.op   = op;
    e.flags = FLAGS_W'($urandom());
    apu_req = req; apu_operands_i = e.ops; apu_op = e.op; apu_flags_i = e.flags;
    flush = fl; issue_ready = rdy; result_valid = rv; result_i = rdata;
    #1;
    outstanding = fq.size() + issued;
    exp_gnt = req && !fl && fq.size() < DEPTH && outstanding < MAX_INFLIGHT;
    exp_iv  = fq.size() != 0 && !fl;
    check("apu_gnt", 128'(apu_gnt), 128'(exp_gnt));
    check("issue_valid", 128'(issue_valid), 128'(exp_iv));
    if (exp_iv) begin
      check("issue_op", 128'(issue_op), 128'(fq[0].op));
      check("issue_operands", 128'(issue_operands), 128'(fq[0].ops));
      check("issue_flags", 128'(issue_flags), 128'(fq[0].flags));
    end
    @(posedge clk);
    #1;
    res_ok = rv && outstanding > 0;
    if (rv && outstanding == 0) m_err = 1;
    if (fl) begin
      fq.delete();
    end else begin
      if (exp_iv && rdy) begin
        void'(fq.pop_front());
        issued++;
      end
      if (exp_gnt) fq.push_back(e);
    end
    if (res_ok) begin
      issued--;
      m_result = rdata;
    end
    m_rvalid = res_ok;
    check_state();
  endtask

  task automatic idle();
    cycle(0, '0, 0, 0, 0, '0);
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && (fq.size() + issued) > 0; i++)
      cycle(0, '0, 0, 1, issued > 0, $urandom());
  endtask

  initial begin
    reset = 1'b1;
    apu_req = 0; apu_operands_i = '0; apu_op = '0; apu_flags_i = '0;
    flush = 0; issue_ready = 0; result_valid = 0; result_i = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 128'(apu_gnt), 128'(0));
    check("rst_issue_valid", 128'(issue_valid), 128'(0));
    check("rst_flags_o", 128'(apu_flags_o), 128'(0));
    check_state();
    reset = 1'b0;
    idle();

    // Fill with back-end stalled: four grants, fifth refused.
    for (int i = 1; i <= 5; i++) cycle(1, OP_W'(i), 0, 0, 0, '0);
    check("full_count", 128'(count_o), 128'(4));
    for (int i = 0; i < 4; i++) cycle(0, '0, 0, 1, 0, '0);
    drain();

    // Streaming: one push and one pop per cycle, results returned as they issue.
    for (int i = 0; i < 21; i++) cycle(1, OP_W'(i), 0, 1, issued > 0, $urandom());
    check("stream_count", 128'(count_o), 128'(1));
    drain();

    // In-flight cap, then one result reopens the grant.
    for (int i = 0; i < 9; i++) cycle(1, OP_W'(i), 0, 1, 0, '0);
    check("cap_gnt", 128'(apu_gnt), 128'(0));
    cycle(1, '0, 0, 1, 1, 32'hDEAD_BEEF);
    check("cap_result", 128'(apu_result), 128'(32'hDEAD_BEEF));
    check("cap_inflight", 128'(inflight_o), 128'(7));
    cycle(1, 6'h2A, 0, 1, 0, '0);
    drain();

    // Flush with two issued and three queued, concurrent with a result.
    cycle(1, 6'h01, 0, 1, 0, '0);
    cycle(1, 6'h02, 0, 1, 0, '0);
    cycle(0, '0, 0, 1, 0, '0);
    for (int i = 3; i <= 5; i++) cycle(1, OP_W'(i), 0, 0, 0, '0);
    check("pre_flush_inflight", 128'(inflight_o), 128'(5));
    cycle(1, 6'h06, 1, 1, 1, 32'h1234_5678);
    check("flush_inflight", 128'(inflight_o), 128'(1));
    idle();
    drain();

    // Spurious result: sticky error, no pulse.
    cycle(0, '0, 0, 0, 1, 32'hBAD0_0001);
    check("spurious_rvalid", 128'(apu_rvalid), 128'(0));
    idle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cycle($urandom_range(0, 3) != 0, OP_W'($urandom()), $urandom_range(0, 15) == 0,
            $urandom_range(0, 2) != 0, issued > 0 && $urandom_range(0, 1) == 1, $urandom());
    drain();

    // Asynchronous reset in the middle of a cycle with three entries queued.
    for (int i = 0; i < 3; i++) cycle(1, OP_W'(i + 7), 0, 0, 0, '0);
    apu_req = 0; issue_ready = 0; result_valid = 0; flush = 0;
    #2 reset = 1'b1;
    #1;
    check("async_rst_count", 128'(count_o), 128'(0));
    check("async_rst_issue_valid", 128'(issue_valid), 128'(0));
    fq.delete(); issued = 0; m_err = 0; m_rvalid = 0; m_result = '0;
    check_state();
    @(posedge clk);
    #1 reset = 1'b0;
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
